// File: rtl/priority_mask_scanner_pkg.sv
// rtl/priority_mask_scanner_pkg.sv - shared state and mode encodings for the priority mask scanner
package priority_mask_scanner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  localparam int DEFAULT_EBW = 4;

endpackage

// File: rtl/priority_mask_scanner_if.sv
// rtl/priority_mask_scanner_if.sv - load and index stream bundle for the priority mask scanner
interface priority_mask_scanner_if #(
  parameter int EBW = 4
);
  localparam int DECBW = 1 << EBW;

  logic             load_valid;
  logic             load_ready;
  logic [DECBW-1:0] load_mask;
  logic             load_mode;
  logic             flush;
  logic             idx_valid;
  logic             idx_ready;
  logic [EBW-1:0]   idx;
  logic             idx_last;
  logic [EBW-1:0]   ptr;

  modport master (
    output load_valid, load_mask, load_mode, flush, idx_ready,
    input  load_ready, idx_valid, idx, idx_last, ptr
  );

  modport slave (
    input  load_valid, load_mask, load_mode, flush, idx_ready,
    output load_ready, idx_valid, idx, idx_last, ptr
  );
endinterface

// File: rtl/priority_mask_scanner_prio_pick.sv
// rtl/priority_mask_scanner_prio_pick.sv - combinational MSB-first picker with optional round-robin start
module priority_mask_scanner_prio_pick #(
  parameter int EBW = 4
) (
  input  logic [(1<<EBW)-1:0] mask,
  input  logic [EBW-1:0]      start,
  input  logic                rr_en,
  output logic [EBW-1:0]      idx,
  output logic                any,
  output logic                one_left
);
  localparam int DECBW = 1 << EBW;

  logic [DECBW-1:0] below_mask;
  logic [EBW-1:0]   below_idx;
  logic [EBW-1:0]   full_idx;
  logic             below_any;

  always_comb begin
    below_mask = mask & ((DECBW'(1) << start) - DECBW'(1));
    below_idx  = '0;
    full_idx   = '0;
    below_any  = 1'b0;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < DECBW; i++) begin
      if (below_mask[i]) begin
        below_idx = EBW'(i);
        below_any = 1'b1;
      end
      if (mask[i]) begin
        full_idx = EBW'(i);
      end
    end
    any      = |mask;
    one_left = any && ((mask & (mask - DECBW'(1))) == '0);
    idx      = (rr_en && below_any) ? below_idx : full_idx;
  end

endmodule

// File: rtl/priority_mask_scanner.sv
// rtl/priority_mask_scanner.sv - emits the index of every set mask bit, one per handshake
module priority_mask_scanner
  import priority_mask_scanner_pkg::*;
#(
  parameter int EBW = DEFAULT_EBW
) (
  input logic                    clk,
  input logic                    rst,
  priority_mask_scanner_if.slave bus
);
  localparam int DECBW = 1 << EBW;

  state_t           state;
  mode_t            mode_q;
  logic [DECBW-1:0] mask_q;
  logic [EBW-1:0]   idx_q;
  logic [EBW-1:0]   ptr_q;
  logic             idx_valid_q;
  logic             idx_last_q;

  logic             handshake;
  logic             load_take;
  logic [DECBW-1:0] next_mask;
  logic [DECBW-1:0] pick_mask;
  logic [EBW-1:0]   pick_start;
  logic             pick_rr;
  logic [EBW-1:0]   pick_idx;
  logic             pick_any;
  logic             pick_one;

  assign handshake = idx_valid_q & bus.idx_ready;
  assign load_take = (state == ST_IDLE) & bus.load_valid & ~bus.flush;
  assign next_mask = mask_q & ~(DECBW'(1) << idx_q);

  // The picker looks ahead: on a load it sees the incoming mask, otherwise the mask
  // left after the current grant, with the grant itself as the new round-robin start.
  assign pick_mask  = load_take ? bus.load_mask : next_mask;
  assign pick_start = load_take ? ptr_q : idx_q;
  assign pick_rr    = load_take ? bus.load_mode : (mode_q == MODE_RR);

  priority_mask_scanner_prio_pick #(.EBW(EBW)) u_pick (
    .mask     (pick_mask),
    .start    (pick_start),
    .rr_en    (pick_rr),
    .idx      (pick_idx),
    .any      (pick_any),
    .one_left (pick_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_FIXED;
      mask_q      <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      idx_valid_q <= 1'b0;
      idx_last_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_take && pick_any) begin
            mask_q      <= bus.load_mask;
            mode_q      <= mode_t'(bus.load_mode);
            idx_q       <= pick_idx;
            idx_last_q  <= pick_one;
            idx_valid_q <= 1'b1;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (handshake) begin
            ptr_q  <= idx_q;
            mask_q <= next_mask;
          end
          if (bus.flush || (handshake && idx_last_q)) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            idx_valid_q <= 1'b0;
            idx_last_q  <= 1'b0;
          end else if (handshake) begin
            idx_q      <= pick_idx;
            idx_last_q <= pick_one;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state == ST_IDLE);
  assign bus.idx_valid  = idx_valid_q;
  assign bus.idx        = idx_q;
  assign bus.idx_last   = idx_last_q;
  assign bus.ptr        = ptr_q;

endmodule
